// File: rtl/cmp_swap_pipe.sv
// cmp_swap_pipe: flow-controlled compare-and-swap element for a bitonic
// sorting network. Orders a pair of {valid, key, value} records by key
// (ascending or descending per pair), registers the result, and presents
// it over a valid/ready handshake backed by a one-entry skid buffer.
// Invalid (padding) records always sink to the second output slot.
//
// Optional feature: define CMP_SWAP_PIPE_STATS_EN to add saturating
// delivered-pair / swapped-pair counters with a synchronous clear.

module cmp_swap_pipe #(
    parameter  int KEY_W      = 32,
    parameter  int VAL_W      = 32,
    parameter  int KEY_SIGNED = 0,
    localparam int REC_W      = KEY_W + VAL_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [REC_W-1:0] in_rec_1,
    input  logic [REC_W-1:0] in_rec_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REC_W-1:0] out_rec_1,
    output logic [REC_W-1:0] out_rec_2,
    output logic             out_swapped
`ifdef CMP_SWAP_PIPE_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_pairs,
    output logic [31:0]      stat_swaps
`endif
);

    // Field extraction from the incoming records.
    logic             valid_1, valid_2;
    logic [KEY_W-1:0] key_1, key_2;

    assign valid_1 = in_rec_1[REC_W-1];
    assign valid_2 = in_rec_2[REC_W-1];
    assign key_1   = in_rec_1[KEY_W+VAL_W-1:VAL_W];
    assign key_2   = in_rec_2[KEY_W+VAL_W-1:VAL_W];

    logic key_gt, key_lt;

    // Key magnitude compare, signed or unsigned depending on the build.
    // NOTE: every output of an always_comb gets a default first so that no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        key_gt = 1'b0;
        key_lt = 1'b0;
        if (KEY_SIGNED != 0) begin
            key_gt = $signed(key_1) > $signed(key_2);
            key_lt = $signed(key_1) < $signed(key_2);
        end else begin
            key_gt = key_1 > key_2;
            key_lt = key_1 < key_2;
        end
    end

    logic swap;

    // Swap decision: equal keys stay put, padding always sinks to slot 2.
    always_comb begin
        swap = 1'b0;
        if (valid_1 && valid_2) begin
            swap = in_dir ? key_lt : key_gt;
        end else if (!valid_1 && valid_2) begin
            swap = 1'b1;
        end
    end

    logic [REC_W-1:0] new_rec_1, new_rec_2;

    assign new_rec_1 = swap ? in_rec_2 : in_rec_1;
    assign new_rec_2 = swap ? in_rec_1 : in_rec_2;

    // Output register (OR) and skid register (SK).
    logic             or_valid;
    logic [REC_W-1:0] or_rec_1, or_rec_2;
    logic             or_swapped;
    logic             sk_full;
    logic [REC_W-1:0] sk_rec_1, sk_rec_2;
    logic             sk_swapped;

    logic accept, deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = or_valid && out_ready;

    // Pipeline storage: refill OR from SK first, otherwise from the input,
    // and park a new pair in SK only when OR is full and stalled.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid   <= 1'b0;
            or_rec_1   <= '0;
            or_rec_2   <= '0;
            or_swapped <= 1'b0;
            sk_full    <= 1'b0;
            sk_rec_1   <= '0;
            sk_rec_2   <= '0;
            sk_swapped <= 1'b0;
        end else begin
            if (deliver && sk_full) begin
                // in_ready is low here, so no accept can coincide.
                or_rec_1   <= sk_rec_1;
                or_rec_2   <= sk_rec_2;
                or_swapped <= sk_swapped;
                sk_full    <= 1'b0;
            end else if (accept) begin
                if (!or_valid || deliver) begin
                    or_valid   <= 1'b1;
                    or_rec_1   <= new_rec_1;
                    or_rec_2   <= new_rec_2;
                    or_swapped <= swap;
                end else begin
                    sk_full    <= 1'b1;
                    sk_rec_1   <= new_rec_1;
                    sk_rec_2   <= new_rec_2;
                    sk_swapped <= swap;
                end
            end else if (deliver) begin
                // Data fields deliberately hold their last value.
                or_valid <= 1'b0;
            end
        end
    end

    // in_ready comes straight from a flop, never from out_ready.
    assign in_ready    = !sk_full;
    assign out_valid   = or_valid;
    assign out_rec_1   = or_rec_1;
    assign out_rec_2   = or_rec_2;
    assign out_swapped = or_swapped;

`ifdef CMP_SWAP_PIPE_STATS_EN
    logic [31:0] stat_pairs_q, stat_swaps_q;

    // Saturating delivery counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pairs_q <= '0;
            stat_swaps_q <= '0;
        end else if (stat_clr) begin
            stat_pairs_q <= '0;
            stat_swaps_q <= '0;
        end else if (deliver) begin
            if (stat_pairs_q != 32'hFFFF_FFFF) begin
                stat_pairs_q <= stat_pairs_q + 32'd1;
            end
            if (or_swapped && (stat_swaps_q != 32'hFFFF_FFFF)) begin
                stat_swaps_q <= stat_swaps_q + 32'd1;
            end
        end
    end

    assign stat_pairs = stat_pairs_q;
    assign stat_swaps = stat_swaps_q;
`endif

endmodule

// File: tb/tb_cmp_swap_pipe.sv
// Self-checking bench for cmp_swap_pipe. Two instances share all inputs:
// one with unsigned keys and one with signed keys (KEY_W=8, VAL_W=8).
// A depth-2 queue model tracks the held pairs; expected ordering comes
// from an integer-level model of the ordering rules.

module tb_cmp_swap_pipe;

    localparam int RW = 17;

    typedef struct packed {
        logic [RW-1:0] o1u, o2u;
        logic          swu;
        logic [RW-1:0] o1s, o2s;
        logic          sws;
    } exp_t;

    typedef struct packed {
        logic [RW-1:0] a, b;
        logic          d;
        logic          sw_u, sw_s;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_dir, out_ready;
    logic [RW-1:0] in_rec_1, in_rec_2;
    logic          u_in_ready, u_out_valid, u_out_swapped;
    logic          s_in_ready, s_out_valid, s_out_swapped;
    logic [RW-1:0] u_out_rec_1, u_out_rec_2, s_out_rec_1, s_out_rec_2;
`ifdef CMP_SWAP_PIPE_STATS_EN
    logic          stat_clr;
    logic [31:0]   u_stat_pairs, u_stat_swaps, s_stat_pairs, s_stat_swaps;
    logic [31:0]   m_pairs, m_swaps_u, m_swaps_s;
`endif

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    exp_t last;

    always #5 clk = ~clk;

    cmp_swap_pipe #(.KEY_W(8), .VAL_W(8), .KEY_SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_dir(in_dir), .in_rec_1(in_rec_1), .in_rec_2(in_rec_2),
        .out_valid(u_out_valid), .out_ready(out_ready),
        .out_rec_1(u_out_rec_1), .out_rec_2(u_out_rec_2), .out_swapped(u_out_swapped)
`ifdef CMP_SWAP_PIPE_STATS_EN
        , .stat_clr(stat_clr), .stat_pairs(u_stat_pairs), .stat_swaps(u_stat_swaps)
`endif
    );

    cmp_swap_pipe #(.KEY_W(8), .VAL_W(8), .KEY_SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_dir(in_dir), .in_rec_1(in_rec_1), .in_rec_2(in_rec_2),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_rec_1(s_out_rec_1), .out_rec_2(s_out_rec_2), .out_swapped(s_out_swapped)
`ifdef CMP_SWAP_PIPE_STATS_EN
        , .stat_clr(stat_clr), .stat_pairs(s_stat_pairs), .stat_swaps(s_stat_swaps)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic v, input logic [7:0] k, input logic [7:0] val);
        return {v, k, val};
    endfunction

    // Ordering rules expressed on plain integers.
    function automatic exp_t model(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic d);
        exp_t e;
        int   ku1, ku2, ks1, ks2;
        logic swu, sws;
        ku1 = int'(a[15:8]);
        ku2 = int'(b[15:8]);
        ks1 = (ku1 > 127) ? ku1 - 256 : ku1;
        ks2 = (ku2 > 127) ? ku2 - 256 : ku2;
        if (a[16] && b[16]) begin
            swu = d ? (ku1 < ku2) : (ku1 > ku2);
            sws = d ? (ks1 < ks2) : (ks1 > ks2);
        end else begin
            swu = !a[16] && b[16];
            sws = swu;
        end
        e.o1u = swu ? b : a;
        e.o2u = swu ? a : b;
        e.swu = swu;
        e.o1s = sws ? b : a;
        e.o2s = sws ? a : b;
        e.sws = sws;
        return e;
    endfunction

    task automatic check_state();
        exp_t f;
        logic has;
        has = (q.size() > 0);
        f = has ? q[0] : last;
        check("u_out_valid", {63'd0, u_out_valid}, {63'd0, has});
        check("s_out_valid", {63'd0, s_out_valid}, {63'd0, has});
        check("u_in_ready", {63'd0, u_in_ready}, {63'd0, q.size() < 2});
        check("s_in_ready", {63'd0, s_in_ready}, {63'd0, q.size() < 2});
        check("u_out_rec_1", 64'(u_out_rec_1), 64'(f.o1u));
        check("u_out_rec_2", 64'(u_out_rec_2), 64'(f.o2u));
        check("u_out_swapped", {63'd0, u_out_swapped}, {63'd0, f.swu});
        check("s_out_rec_1", 64'(s_out_rec_1), 64'(f.o1s));
        check("s_out_rec_2", 64'(s_out_rec_2), 64'(f.o2s));
        check("s_out_swapped", {63'd0, s_out_swapped}, {63'd0, f.sws});
`ifdef CMP_SWAP_PIPE_STATS_EN
        check("u_stat_pairs", 64'(u_stat_pairs), 64'(m_pairs));
        check("u_stat_swaps", 64'(u_stat_swaps), 64'(m_swaps_u));
        check("s_stat_pairs", 64'(s_stat_pairs), 64'(m_pairs));
        check("s_stat_swaps", 64'(s_stat_swaps), 64'(m_swaps_s));
`endif
    endtask

    // One clock: drive inputs, predict handshakes, advance model, compare.
    task automatic cycle(input logic v, input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic d, input logic ordy);
        logic acc, dlv;
        exp_t e;
        in_valid  = v;
        in_rec_1  = a;
        in_rec_2  = b;
        in_dir    = d;
        out_ready = ordy;
        acc = v && (q.size() < 2);
        dlv = (q.size() > 0) && ordy;
        e = model(a, b, d);
        @(posedge clk);
        #1;
`ifdef CMP_SWAP_PIPE_STATS_EN
        if (stat_clr) begin
            m_pairs = 0; m_swaps_u = 0; m_swaps_s = 0;
        end else if (dlv) begin
            if (m_pairs != 32'hFFFF_FFFF) m_pairs = m_pairs + 1;
            if (q[0].swu && m_swaps_u != 32'hFFFF_FFFF) m_swaps_u = m_swaps_u + 1;
            if (q[0].sws && m_swaps_s != 32'hFFFF_FFFF) m_swaps_s = m_swaps_s + 1;
        end
`endif
        if (dlv) last = q.pop_front();
        if (acc) q.push_back(e);
        check_state();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, ordy);
    endtask

    vec_t tbl[9];

    initial begin
        // {a, b, dir, unsigned swap, signed swap}
        tbl[0] = '{mk(1, 8'd9,   8'hAA), mk(1, 8'd3,   8'hBB), 1'b0, 1'b1, 1'b1};
        tbl[1] = '{mk(1, 8'd5,   8'h11), mk(1, 8'd5,   8'h22), 1'b1, 1'b0, 1'b0};
        tbl[2] = '{mk(1, 8'd2,   8'h33), mk(1, 8'd7,   8'h44), 1'b1, 1'b1, 1'b1};
        tbl[3] = '{mk(1, 8'hFF,  8'h55), mk(1, 8'h01,  8'h66), 1'b0, 1'b1, 1'b0};
        tbl[4] = '{mk(0, 8'd0,   8'h77), mk(1, 8'd100, 8'h88), 1'b0, 1'b1, 1'b1};
        tbl[5] = '{mk(0, 8'd0,   8'h77), mk(1, 8'd100, 8'h88), 1'b1, 1'b1, 1'b1};
        tbl[6] = '{mk(1, 8'd1,   8'h99), mk(0, 8'd200, 8'h12), 1'b1, 1'b0, 1'b0};
        tbl[7] = '{mk(0, 8'd9,   8'h34), mk(0, 8'd3,   8'h56), 1'b0, 1'b0, 1'b0};
        tbl[8] = '{mk(1, 8'h80,  8'h78), mk(1, 8'h7F,  8'h9A), 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_dir = 1'b0; out_ready = 1'b0;
        in_rec_1 = '0; in_rec_2 = '0;
        last = '0;
`ifdef CMP_SWAP_PIPE_STATS_EN
        stat_clr = 1'b0;
        m_pairs = 0; m_swaps_u = 0; m_swaps_s = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back-to-back with out_ready high.
        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].d, 1'b1);
            check($sformatf("tbl%0d_u_swapped", i), {63'd0, u_out_swapped}, {63'd0, tbl[i].sw_u});
            check($sformatf("tbl%0d_s_swapped", i), {63'd0, s_out_swapped}, {63'd0, tbl[i].sw_s});
            check($sformatf("tbl%0d_u_rec_1", i), 64'(u_out_rec_1),
                  64'(tbl[i].sw_u ? tbl[i].b : tbl[i].a));
            check($sformatf("tbl%0d_s_rec_1", i), 64'(s_out_rec_1),
                  64'(tbl[i].sw_s ? tbl[i].b : tbl[i].a));
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure: P0 in OR, P1 in SK, P2 held off, then release.
        cycle(1'b1, mk(1, 8'd10, 8'h00), mk(1, 8'd20, 8'h01), 1'b1, 1'b0);
        cycle(1'b1, mk(1, 8'd30, 8'h02), mk(1, 8'd25, 8'h03), 1'b0, 1'b0);
        check("bp_in_ready_low", {63'd0, u_in_ready}, 64'd0);
        repeat (3) cycle(1'b1, mk(1, 8'd4, 8'h04), mk(1, 8'd6, 8'h05), 1'b1, 1'b0);
        check("bp_p0_stable", 64'(u_out_rec_1), 64'(mk(1, 8'd20, 8'h01)));
        repeat (2) cycle(1'b1, mk(1, 8'd4, 8'h04), mk(1, 8'd6, 8'h05), 1'b1, 1'b1);
        cycle(1'b1, mk(1, 8'd8, 8'h06), mk(0, 8'd1, 8'h07), 1'b0, 1'b1);
        check("bp_p3_swapped", {63'd0, u_out_swapped}, 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Async reset with OR and SK both full.
        cycle(1'b1, mk(1, 8'd1, 8'h10), mk(1, 8'd2, 8'h11), 1'b0, 1'b0);
        cycle(1'b1, mk(1, 8'd3, 8'h12), mk(1, 8'd4, 8'h13), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        last = '0;
`ifdef CMP_SWAP_PIPE_STATS_EN
        m_pairs = 0; m_swaps_u = 0; m_swaps_s = 0;
`endif
        check("rst_u_out_valid", {63'd0, u_out_valid}, 64'd0);
        check("rst_u_in_ready", {63'd0, u_in_ready}, 64'd1);
        check("rst_s_out_valid", {63'd0, s_out_valid}, 64'd0);
        check("rst_s_in_ready", {63'd0, s_in_ready}, 64'd1);
        check("rst_u_out_rec_1", 64'(u_out_rec_1), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, mk(1, 8'd50, 8'h20), mk(1, 8'd40, 8'h21), 1'b0, 1'b1);
        check("rst_latency1", {63'd0, u_out_valid}, 64'd1);
        idle(1'b1);

        // Randomised traffic with ties and padding mixed in.
        for (int n = 0; n < 400; n++) begin
            logic [RW-1:0] a, b;
            a = mk($urandom_range(0, 4) != 0, 8'($urandom), 8'($urandom));
            b = mk($urandom_range(0, 4) != 0, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) b[15:8] = a[15:8];
            cycle($urandom_range(0, 3) != 0, a, b, 1'($urandom), 1'($urandom));
        end
        repeat (3) idle(1'b1);

`ifdef CMP_SWAP_PIPE_STATS_EN
        stat_clr = 1'b1;
        idle(1'b1);
        stat_clr = 1'b0;
        check("stat_clr_pairs", 64'(u_stat_pairs), 64'd0);
        check("stat_clr_swaps", 64'(u_stat_swaps), 64'd0);
        cycle(1'b1, tbl[0].a, tbl[0].b, tbl[0].d, 1'b1);
        cycle(1'b1, tbl[1].a, tbl[1].b, tbl[1].d, 1'b1);
        cycle(1'b1, tbl[2].a, tbl[2].b, tbl[2].d, 1'b1);
        cycle(1'b1, tbl[4].a, tbl[4].b, tbl[4].d, 1'b1);
        idle(1'b1);
        check("stat_pairs_4", 64'(u_stat_pairs), 64'd4);
        check("stat_swaps_3", 64'(u_stat_swaps), 64'd3);
        // Clear coinciding with a delivery.
        cycle(1'b1, tbl[0].a, tbl[0].b, tbl[0].d, 1'b1);
        stat_clr = 1'b1;
        idle(1'b1);
        stat_clr = 1'b0;
        check("stat_clr_prio", 64'(u_stat_pairs), 64'd0);
        // Saturation.
        @(negedge clk);
        force u_dut.stat_pairs_q = 32'hFFFF_FFFF;
        force s_dut.stat_pairs_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.stat_pairs_q;
        release s_dut.stat_pairs_q;
        m_pairs = 32'hFFFF_FFFF;
        cycle(1'b1, tbl[0].a, tbl[0].b, tbl[0].d, 1'b1);
        idle(1'b1);
        check("stat_pairs_sat", 64'(u_stat_pairs), 64'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
